// File: rtl/mtra_multiplier.sv
// rtl/mtra_multiplier.sv - unsigned repeated-addition multiplier, serial A/B operand load
// Optional sticky overflow flag when MTRA_OVF_EN is defined.
module mtra_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
`ifdef MTRA_OVF_EN
  output logic             overflow,
`endif
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic             r_done;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_sum;

`ifdef MTRA_OVF_EN
  logic [WIDTH:0]   w_sum_full;
  logic             r_ovf;

  assign w_sum_full = {1'b0, r_p} + {1'b0, r_a};
  assign w_sum      = w_sum_full[WIDTH-1:0];
  assign overflow   = r_ovf;
`else
  assign w_sum      = r_p + r_a;
`endif

  assign w_b_zero = (r_b == '0);
  assign product  = r_p;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD_A;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_CALC;
      S_CALC:   if (w_b_zero) w_next = S_DONE;
      S_DONE:   if (!start) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // done is decoded from the next state so it is high exactly while in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      case (r_state)
        S_LOAD_A: r_a <= data_in;
        S_LOAD_B: begin
          r_b <= data_in;
          r_p <= '0;
        end
        S_CALC: begin
          if (!w_b_zero) begin
            r_p <= w_sum;
            r_b <= r_b - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MTRA_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_LOAD_B) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_CALC && !w_b_zero && w_sum_full[WIDTH]) begin
      r_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mtra_multiplier.sv
// tb/tb_mtra_multiplier.sv - directed-vector self-checking bench for mtra_multiplier
// Overflow checks are compiled in when MTRA_OVF_EN is defined.
module tb_mtra_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] product;
  logic        done;
`ifdef MTRA_OVF_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;

  mtra_multiplier #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .product  (product),
`ifdef MTRA_OVF_EN
    .overflow (overflow),
`endif
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives A in LOAD_A and B in LOAD_B, then counts CALC cycles until done
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int n);
    start   = 1'b1;
    data_in = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = b;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", product, 0);
    check("reset_done", done, 0);
`ifdef MTRA_OVF_EN
    check("reset_ovf", overflow, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd20, 16'd5, cyc);
    check("t1_cycles", cyc, 6);
    check("t1_product", product, 100);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_held", done, 1);
    check("t1_product_held", product, 100);
    release_start();
    check("t1_done_low", done, 0);

    run_op(16'd7, 16'd0, cyc);
    check("t2_cycles", cyc, 1);
    check("t2_product", product, 0);
    release_start();

    run_op(16'd0, 16'd3, cyc);
    check("t3_cycles", cyc, 4);
    check("t3_product", product, 0);
    release_start();

    run_op(16'd300, 16'd300, cyc);
    check("t4_cycles", cyc, 301);
    check("t4_product", product, 24464);
`ifdef MTRA_OVF_EN
    check("t4_ovf", overflow, 1);
`endif
    release_start();

    run_op(16'd255, 16'd255, cyc);
    check("t4b_product", product, 65025);
`ifdef MTRA_OVF_EN
    check("t4b_ovf", overflow, 0);
`endif
    release_start();

    // Abort mid-CALC: after two adds P is 40, reset must clear it immediately
    start   = 1'b1;
    data_in = 16'd20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = 16'd5;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_mid_product", product, 40);
    rst_n = 1'b0;
    #1;
    check("t5_rst_done", done, 0);
    check("t5_rst_product", product, 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd3, 16'd4, cyc);
    check("t5_product", product, 12);
    release_start();

    run_op(16'd20, 16'd5, cyc);
    check("t6_first", product, 100);
    release_start();
    check("t6_idle_done", done, 0);
    run_op(16'd6, 16'd7, cyc);
    check("t6_cycles", cyc, 8);
    check("t6_product", product, 42);
    check("t6_done", done, 1);
    release_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
